// File: rtl/lcd_pkg.sv
// Shared constants, state encoding and step helpers for the LCD sequencer.
package lcd_pkg;

    // HD44780 command bytes
    localparam logic [7:0] CMD_FUNC_SET = 8'h38;  // 8-bit bus, 2 lines, 5x8 font
    localparam logic [7:0] CMD_DISP_ON  = 8'h0C;  // display on, cursor off
    localparam logic [7:0] CMD_ENTRY    = 8'h06;  // increment, no shift
    localparam logic [7:0] CMD_CLEAR    = 8'h01;  // clear display
    localparam logic [7:0] CMD_LINE1    = 8'h80;  // DDRAM address 0x00
    localparam logic [7:0] CMD_LINE2    = 8'hC0;  // DDRAM address 0x40

    // Step count constants
    localparam logic [5:0] INIT_LAST_STEP = 6'd3;   // clear is the last init command
    localparam logic [5:0] REF_LINE2_STEP = 6'd17;  // line-2 address command
    localparam logic [5:0] REF_LAST_STEP  = 6'd33;  // final character of line 2

    typedef enum logic [2:0] {
        ST_POWER = 3'd0,
        ST_ISSUE = 3'd1,
        ST_WAIT  = 3'd2,
        ST_DELAY = 3'd3,
        ST_READY = 3'd4
    } lcd_state_t;

    // Command byte for a given init step
    function automatic logic [7:0] init_cmd(input logic [5:0] step);
        logic [7:0] cmd;
        case (step)
            6'd0:    cmd = CMD_FUNC_SET;
            6'd1:    cmd = CMD_DISP_ON;
            6'd2:    cmd = CMD_ENTRY;
            default: cmd = CMD_CLEAR;
        endcase
        return cmd;
    endfunction

    // Frame-buffer address read by a refresh step (modulo-32 arithmetic)
    function automatic logic [4:0] char_addr_of(input logic [5:0] step);
        logic [4:0] addr;
        if (step >= 6'd1 && step <= REF_LINE2_STEP) begin
            addr = step[4:0] - 5'd1;
        end else if (step > REF_LINE2_STEP && step <= REF_LAST_STEP) begin
            addr = step[4:0] - 5'd2;
        end else begin
            addr = 5'd0;
        end
        return addr;
    endfunction

endpackage

// File: rtl/lcd_sequencer_ms_delay_counter.sv
// Loadable millisecond down-counter; sticks at zero and flags it.
module ms_delay_counter #(
    parameter int unsigned WIDTH = 32'd16
) (
    input  logic             clk_1ms,
    input  logic             reset,
    input  logic             load,
    input  logic [WIDTH-1:0] load_val,
    output logic             zero
);

    logic [WIDTH-1:0] count_r;

    // Load has priority; otherwise decrement until zero is reached
    always_ff @(posedge clk_1ms or posedge reset) begin
        if (reset) begin
            count_r <= '0;
        end else if (load) begin
            count_r <= load_val;
        end else if (count_r != '0) begin
            count_r <= count_r - {{(WIDTH-1){1'b0}}, 1'b1};
        end else begin
            count_r <= count_r;
        end
    end

    assign zero = (count_r == '0);

endmodule

// File: rtl/lcd_sequencer.sv
// Power-on init and frame refresh sequencer for a 16x2 HD44780 LCD.
module lcd_sequencer
    import lcd_pkg::*;
#(
    parameter int unsigned PWR_WAIT = 32'd20,
    parameter int unsigned CLR_WAIT = 32'd2
) (
    input  logic       clk_1ms,
    input  logic       reset,
    input  logic       refresh,
    input  logic [7:0] char_data,
    output logic [4:0] char_addr,
    input  logic       wr_finish,
    output logic       wr_enable,
    output logic       reg_sel,
    output logic [7:0] lcd_data,
    output logic       ready,
    output logic       done
);

    localparam int unsigned CNT_W = 32'd16;
    // Counter is loaded on the transition edge, so it holds N-1 to span N cycles
    localparam logic [CNT_W-1:0] PWR_LOAD = (PWR_WAIT > 32'd0) ? CNT_W'(PWR_WAIT - 32'd1) : '0;
    localparam logic [CNT_W-1:0] CLR_LOAD = (CLR_WAIT > 32'd0) ? CNT_W'(CLR_WAIT - 32'd1) : '0;

    lcd_state_t       state_r, state_s;
    logic [5:0]       step_r, step_s;
    logic             mode_r, mode_s;        // 0 = init list, 1 = refresh list
    logic             pending_r, pending_s;
    logic             armed_r, armed_s;      // power-up wait has been loaded
    logic             cnt_load_s;
    logic [CNT_W-1:0] cnt_val_s;
    logic             cnt_zero_s;
    logic             start_ref_s;
    logic             wr_enable_r, wr_enable_s;
    logic             reg_sel_r, reg_sel_s;
    logic [7:0]       lcd_data_r, lcd_data_s;
    logic [4:0]       char_addr_r, char_addr_s;
    logic             ready_r, ready_s;
    logic             done_r, done_s;

    ms_delay_counter #(.WIDTH(CNT_W)) u_delay (
        .clk_1ms  (clk_1ms),
        .reset    (reset),
        .load     (cnt_load_s),
        .load_val (cnt_val_s),
        .zero     (cnt_zero_s)
    );

    // Next-state, step/pending bookkeeping and next output values
    always_comb begin
        state_s     = state_r;
        step_s      = step_r;
        mode_s      = mode_r;
        armed_s     = armed_r;
        pending_s   = pending_r;
        cnt_load_s  = 1'b0;
        cnt_val_s   = '0;
        start_ref_s = 1'b0;
        done_s      = 1'b0;

        case (state_r)
            ST_POWER: begin
                if (!armed_r) begin
                    cnt_load_s = 1'b1;
                    cnt_val_s  = PWR_LOAD;
                    armed_s    = 1'b1;
                end else if (cnt_zero_s) begin
                    state_s = ST_ISSUE;
                    step_s  = 6'd0;
                    mode_s  = 1'b0;
                end else begin
                    state_s = ST_POWER;
                end
            end
            ST_ISSUE: begin
                state_s = ST_WAIT;
            end
            ST_WAIT: begin
                if (!wr_finish) begin
                    state_s = ST_WAIT;
                end else if (!mode_r && step_r == INIT_LAST_STEP) begin
                    state_s    = ST_DELAY;
                    cnt_load_s = 1'b1;
                    cnt_val_s  = CLR_LOAD;
                end else if (mode_r && step_r == REF_LAST_STEP) begin
                    done_s      = 1'b1;
                    state_s     = ST_READY;
                    start_ref_s = pending_r | refresh;
                end else begin
                    step_s  = step_r + 6'd1;
                    state_s = ST_ISSUE;
                end
            end
            ST_DELAY: begin
                if (cnt_zero_s) begin
                    state_s     = ST_READY;
                    start_ref_s = pending_r | refresh;
                end else begin
                    state_s = ST_DELAY;
                end
            end
            ST_READY: begin
                start_ref_s = refresh;
            end
            default: begin
                state_s = ST_POWER;
            end
        endcase

        // A request waiting at the point of going idle starts straight away
        if (start_ref_s) begin
            state_s   = ST_ISSUE;
            step_s    = 6'd0;
            mode_s    = 1'b1;
            pending_s = 1'b0;
        end else begin
            pending_s = pending_r | (refresh & (state_r != ST_READY));
        end

        wr_enable_s = (state_s == ST_ISSUE);
        ready_s     = (state_s == ST_READY);
        // Point the buffer at the next step's byte so it is ready when ISSUE samples it
        char_addr_s = mode_s ? char_addr_of(step_s + 6'd1) : 5'd0;

        if (state_s != ST_ISSUE) begin
            lcd_data_s = lcd_data_r;
            reg_sel_s  = reg_sel_r;
        end else if (!mode_s) begin
            lcd_data_s = init_cmd(step_s);
            reg_sel_s  = 1'b0;
        end else if (step_s == 6'd0) begin
            lcd_data_s = CMD_LINE1;
            reg_sel_s  = 1'b0;
        end else if (step_s == REF_LINE2_STEP) begin
            lcd_data_s = CMD_LINE2;
            reg_sel_s  = 1'b0;
        end else begin
            lcd_data_s = char_data;
            reg_sel_s  = 1'b1;
        end
    end

    // State and sequencing registers
    always_ff @(posedge clk_1ms or posedge reset) begin
        if (reset) begin
            state_r   <= ST_POWER;
            step_r    <= 6'd0;
            mode_r    <= 1'b0;
            pending_r <= 1'b0;
            armed_r   <= 1'b0;
        end else begin
            state_r   <= state_s;
            step_r    <= step_s;
            mode_r    <= mode_s;
            pending_r <= pending_s;
            armed_r   <= armed_s;
        end
    end

    // Registered outputs
    always_ff @(posedge clk_1ms or posedge reset) begin
        if (reset) begin
            wr_enable_r <= 1'b0;
            reg_sel_r   <= 1'b0;
            lcd_data_r  <= 8'h00;
            char_addr_r <= 5'd0;
            ready_r     <= 1'b0;
            done_r      <= 1'b0;
        end else begin
            wr_enable_r <= wr_enable_s;
            reg_sel_r   <= reg_sel_s;
            lcd_data_r  <= lcd_data_s;
            char_addr_r <= char_addr_s;
            ready_r     <= ready_s;
            done_r      <= done_s;
        end
    end

    assign wr_enable = wr_enable_r;
    assign reg_sel   = reg_sel_r;
    assign lcd_data  = lcd_data_r;
    assign char_addr = char_addr_r;
    assign ready     = ready_r;
    assign done      = done_r;

endmodule

// File: tb/tb_lcd_sequencer.sv
// Self-checking bench: write-engine model plus expected byte lists built from the command set.
module tb_lcd_sequencer;

    localparam int unsigned PWR_WAIT = 20;
    localparam int unsigned CLR_WAIT = 2;

    logic       clk_1ms = 1'b0;
    logic       reset;
    logic       refresh;
    logic       wr_finish;
    logic [7:0] char_data;
    logic [4:0] char_addr;
    logic       wr_enable;
    logic       reg_sel;
    logic [7:0] lcd_data;
    logic       ready;
    logic       done;
    logic [7:0] fbuf [32];

    always #5 clk_1ms = ~clk_1ms;

    assign char_data = fbuf[char_addr];

    lcd_sequencer #(.PWR_WAIT(PWR_WAIT), .CLR_WAIT(CLR_WAIT)) dut (
        .clk_1ms   (clk_1ms),
        .reset     (reset),
        .refresh   (refresh),
        .char_data (char_data),
        .char_addr (char_addr),
        .wr_finish (wr_finish),
        .wr_enable (wr_enable),
        .reg_sel   (reg_sel),
        .lcd_data  (lcd_data),
        .ready     (ready),
        .done      (done)
    );

    int         chk = 0;
    int         err = 0;
    int         cyc;
    logic [8:0] obs_q [$];
    logic [8:0] exp_q [$];
    int         first_we_cyc, last_fin_cyc, ready_rise_cyc, done_cyc, done_cnt, fin_cnt;
    bit         eng_busy;
    int         eng_cnt;
    int         eng_lat;
    bit         eng_rand;
    logic [8:0] held;
    bit         prev_ready;
    bit         ready_bad;

    task automatic check(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        chk++;
        assert (observed === expected) else begin
            err++;
            $error("FAIL %s observed=%0h expected=%0h", tag, observed, expected);
        end
    endtask

    // One clock cycle: sample DUT at the falling edge and run the write-engine model
    task automatic cycle();
        @(negedge clk_1ms);
        cyc++;
        wr_finish = 1'b0;
        refresh   = 1'b0;
        if (wr_enable === 1'b1) begin
            check("we_while_busy", {31'd0, eng_busy}, 32'd0);
            obs_q.push_back({reg_sel, lcd_data});
            if (first_we_cyc < 0) first_we_cyc = cyc;
            held     = {reg_sel, lcd_data};
            eng_busy = 1'b1;
            eng_cnt  = eng_rand ? int'($urandom_range(1, 6)) : eng_lat;
        end else if (eng_busy) begin
            check("hold_during_wait", {23'd0, reg_sel, lcd_data}, {23'd0, held});
            eng_cnt--;
            if (eng_cnt == 0) begin
                wr_finish    = 1'b1;
                eng_busy     = 1'b0;
                fin_cnt++;
                last_fin_cyc = cyc;
            end
        end
        if (done === 1'b1) begin
            done_cnt++;
            done_cyc = cyc;
        end
        if (ready === 1'b1 && !prev_ready && ready_rise_cyc < 0) ready_rise_cyc = cyc;
        prev_ready = (ready === 1'b1);
    endtask

    task automatic clear_tracking();
        obs_q.delete();
        first_we_cyc   = -1;
        last_fin_cyc   = -1;
        ready_rise_cyc = -1;
        done_cyc       = -1;
        done_cnt       = 0;
        fin_cnt        = 0;
        ready_bad      = 1'b0;
    endtask

    task automatic release_reset();
        repeat (2) @(negedge clk_1ms);
        reset      = 1'b0;
        cyc        = 0;
        prev_ready = 1'b0;
        clear_tracking();
    endtask

    task automatic build_init();
        exp_q.delete();
        exp_q.push_back(9'h038);
        exp_q.push_back(9'h00C);
        exp_q.push_back(9'h006);
        exp_q.push_back(9'h001);
    endtask

    task automatic append_refresh();
        exp_q.push_back({1'b0, 8'h80});
        for (int i = 0; i < 16; i++) exp_q.push_back({1'b1, fbuf[i]});
        exp_q.push_back({1'b0, 8'hC0});
        for (int i = 16; i < 32; i++) exp_q.push_back({1'b1, fbuf[i]});
    endtask

    task automatic compare_writes(input string tag);
        check({tag, "_count"}, obs_q.size(), exp_q.size());
        for (int i = 0; i < exp_q.size(); i++) begin
            check($sformatf("%s_byte%0d", tag, i), {23'd0, obs_q[i]}, {23'd0, exp_q[i]});
        end
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_wr_enable"}, {31'd0, wr_enable}, 32'd0);
        check({tag, "_reg_sel"},   {31'd0, reg_sel},   32'd0);
        check({tag, "_lcd_data"},  {24'd0, lcd_data},  32'd0);
        check({tag, "_char_addr"}, {27'd0, char_addr}, 32'd0);
        check({tag, "_ready"},     {31'd0, ready},     32'd0);
        check({tag, "_done"},      {31'd0, done},      32'd0);
    endtask

    // Run a refresh from the ready state and check bytes, latency and done/ready
    task automatic run_refresh(input string tag);
        int start;
        clear_tracking();
        exp_q.delete();
        append_refresh();
        refresh = 1'b1;
        start   = cyc;
        while (done_cnt == 0 && cyc < start + 2000) begin
            cycle();
            if (done_cnt == 0 && ready === 1'b1) ready_bad = 1'b1;
        end
        check({tag, "_first_we"}, first_we_cyc, start + 1);
        compare_writes(tag);
        check({tag, "_done_latency"}, done_cyc, last_fin_cyc + 1);
        check({tag, "_ready_with_done"}, {31'd0, ready}, 32'd1);
        check({tag, "_ready_low_busy"}, {31'd0, ready_bad}, 32'd0);
        repeat (5) cycle();
        check({tag, "_no_extra"}, obs_q.size(), 34);
        check({tag, "_one_done"}, done_cnt, 1);
    endtask

    initial begin
        reset     = 1'b0;
        refresh   = 1'b0;
        wr_finish = 1'b0;
        eng_busy  = 1'b0;
        eng_lat   = 3;
        eng_rand  = 1'b0;
        cyc       = 0;
        for (int i = 0; i < 32; i++) fbuf[i] = 8'h41 + 8'(i);
        #1 reset = 1'b1;
        repeat (2) @(negedge clk_1ms);
        check_reset_outputs("reset");
        release_reset();

        // Init with spurious wr_finish in POWER and DELAY
        build_init();
        while (ready !== 1'b1 && cyc < 200) begin
            cycle();
            if (cyc == 5 || cyc == 12) wr_finish = 1'b1;
            if (fin_cnt == 4 && cyc == last_fin_cyc + 1) wr_finish = 1'b1;
        end
        check("init_ready", {31'd0, ready}, 32'd1);
        check("init_first_we", first_we_cyc, PWR_WAIT + 1);
        compare_writes("init");
        check("init_ready_delay", ready_rise_cyc, last_fin_cyc + CLR_WAIT + 1);
        check("init_no_done", done_cnt, 0);

        // Refresh of 'A'+i with fixed latency
        run_refresh("ref_abc");

        // Random frame, random engine latency
        for (int i = 0; i < 32; i++) fbuf[i] = 8'($urandom());
        eng_rand = 1'b1;
        run_refresh("ref_rand");

        // Engine stalls 10 cycles on every byte
        for (int i = 0; i < 32; i++) fbuf[i] = 8'($urandom());
        eng_rand = 1'b0;
        eng_lat  = 10;
        run_refresh("ref_stall");

        // Two refresh requests during init collapse into one refresh
        eng_lat  = 3;
        reset    = 1'b1;
        eng_busy = 1'b0;
        release_reset();
        build_init();
        append_refresh();
        while (done_cnt == 0 && cyc < 3000) begin
            cycle();
            if (cyc == 8 || cyc == 24) refresh = 1'b1;
            if (done_cnt == 0 && ready === 1'b1) ready_bad = 1'b1;
        end
        compare_writes("pend");
        check("pend_ready_low", {31'd0, ready_bad}, 32'd0);
        check("pend_ready_with_done", {31'd0, ready}, 32'd1);
        repeat (10) cycle();
        check("pend_single_refresh", obs_q.size(), 38);
        check("pend_one_done", done_cnt, 1);

        // Reset asserted at refresh step 10 aborts and reruns init
        clear_tracking();
        refresh = 1'b1;
        begin
            int start;
            start = cyc;
            while (obs_q.size() < 11 && cyc < start + 500) cycle();
        end
        check("abort_reached_step10", obs_q.size(), 11);
        #2 reset = 1'b1;
        eng_busy  = 1'b0;
        wr_finish = 1'b0;
        #1 check_reset_outputs("abort");
        release_reset();
        build_init();
        while (ready !== 1'b1 && cyc < 200) cycle();
        check("rerun_first_we", first_we_cyc, PWR_WAIT + 1);
        compare_writes("rerun");
        check("rerun_ready_delay", ready_rise_cyc, last_fin_cyc + CLR_WAIT + 1);
        check("rerun_no_done", done_cnt, 0);

        $display("CHECKS %0d ERRORS %0d", chk, err);
        $finish;
    end

endmodule
